reservation_station: RTL and testbench

- Issue queue for one functional-unit class (ALU, MEM or BR).
- Sits directly downstream of dispatch: accepts dispatch_pipeline_data records, holds them as rs_data entries and tracks operand readiness from the CDB tag broadcast.
- Each cycle it issues the oldest entry with both operands ready to its FU.
- One instance per FU class; FU_ID is stamped into each issued record.

---
 rtl/reservation_station_pkg.sv | 45 ++++
 rtl/reservation_station_age_select.sv | 29 ++
 rtl/reservation_station.sv | 167 ++++++++++++++++
 tb/tb_reservation_station.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: the dispatch record, the stored
// entry record, FU class codes and the physical register tag width.
// The optional wakeup bypass is enabled with the macro RS_WAKEUP_BYPASS_EN.
package reservation_station_pkg;

  localparam int PREG_W = 7;

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_MEM = 2'd1;
  localparam logic [1:0] FU_BR  = 2'd2;

  typedef struct packed {
    logic [6:0]        Opcode;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] pr1;
    logic              pr1_ready;
    logic [PREG_W-1:0] pr2;
    logic              pr2_ready;
    logic [31:0]       imm;
    logic [4:0]        rob_index;
  } dispatch_pipeline_data;

  typedef struct packed {
    logic              valid;
    logic [1:0]        fu;
    logic [6:0]        Opcode;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] pr1;
    logic              pr1_ready;
    logic [PREG_W-1:0] pr2;
    logic              pr2_ready;
    logic [31:0]       imm;
    logic [4:0]        rob_index;
    logic [2:0]        age;
  } rs_data;

  // True when a valid, non-zero CDB broadcast names this source register.
  // Tag 0 is the hardwired-ready register and is never a wakeup target.
  function automatic logic cdb_match(input logic              valid,
                                     input logic [PREG_W-1:0] tag,
                                     input logic [PREG_W-1:0] pr);
    return valid && (tag != '0) && (tag == pr);
  endfunction

endpackage

// File: rtl/reservation_station_age_select.sv
// Combinational minimum-age picker. Ages among requesting entries are unique,
// so the grant is one-hot whenever found_o is set and all-zero otherwise.
module reservation_station_age_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]   req_i,
  input  logic [DEPTH*3-1:0] age_i,
  output logic [DEPTH-1:0]   grant_o,
  output logic               found_o
);

  logic [2:0] best_age;

  // Linear scan keeping the youngest-numbered (oldest) requester seen so far.
  always_comb begin
    grant_o  = '0;
    found_o  = 1'b0;
    best_age = 3'd7;
    for (int i = 0; i < DEPTH; i++) begin
      if (req_i[i] && (!found_o || (age_i[i*3 +: 3] < best_age))) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        best_age   = age_i[i*3 +: 3];
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Issue queue for one FU class. Holds dispatched instructions, wakes operands
// from the CDB and issues the oldest ready entry each cycle.
// Optional feature macro: RS_WAKEUP_BYPASS_EN (same-cycle CDB wakeup counts
// toward eligibility). DEPTH must be at most 8 so the 3-bit age fits.
//
// Handshakes: a transfer happens on a clock edge where valid && ready are
// both high; the sender holds valid and data stable until it transfers, and
// ready never depends combinationally on the same interface's valid.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int         DEPTH = 8,
  parameter logic [1:0] FU_ID = 2'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  disp_valid,
  input  dispatch_pipeline_data disp_data,
  output logic                  disp_ready,
  input  logic                  cdb_valid,
  input  logic [PREG_W-1:0]     cdb_tag,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output rs_data                issue_data,
  output logic [3:0]            occupancy
);

  rs_data     entries_q [DEPTH];
  rs_data     entries_d [DEPTH];
  logic [3:0] count_q, count_d;

  logic [DEPTH-1:0]   elig;
  logic [DEPTH-1:0]   grant;
  logic [DEPTH-1:0]   ins_sel;
  logic [DEPTH*3-1:0] ages_flat;
  logic               found;
  logic               insert;
  logic               fire;
  logic [2:0]         sel_age;
  rs_data             new_entry;

  // disp_ready comes only from the registered count, so a slot freed by an
  // issue this cycle is offered to dispatch on the following cycle.
  assign disp_ready  = (count_q < 4'(DEPTH));
  assign insert      = disp_valid && disp_ready;
  assign issue_valid = found;
  assign fire        = issue_valid && issue_ready;
  assign occupancy   = count_q;

  // Per-entry eligibility on the registered ready bits, optionally widened
  // by this cycle's CDB tag.
  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
      elig[i] = entries_q[i].valid
             && (entries_q[i].pr1_ready || cdb_match(cdb_valid, cdb_tag, entries_q[i].pr1))
             && (entries_q[i].pr2_ready || cdb_match(cdb_valid, cdb_tag, entries_q[i].pr2));
`else
      elig[i] = entries_q[i].valid && entries_q[i].pr1_ready && entries_q[i].pr2_ready;
`endif
      ages_flat[i*3 +: 3] = entries_q[i].age;
    end
  end

  reservation_station_age_select #(
    .DEPTH (DEPTH)
  ) u_age_select (
    .req_i   (elig),
    .age_i   (ages_flat),
    .grant_o (grant),
    .found_o (found)
  );

  // Mux out the granted entry; all-zero when nothing is eligible.
  always_comb begin
    issue_data = '0;
    sel_age    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        issue_data = entries_q[i];
        sel_age    = entries_q[i].age;
      end
    end
  end

  // Lowest-index free slot for a new dispatch (descending scan, lowest wins).
  always_comb begin
    ins_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        ins_sel    = '0;
        ins_sel[i] = 1'b1;
      end
    end
  end

  // Build the stored form of the incoming instruction, catching a wakeup
  // that coincides with dispatch.
  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.fu        = FU_ID;
    new_entry.Opcode    = disp_data.Opcode;
    new_entry.prd       = disp_data.prd;
    new_entry.pr1       = disp_data.pr1;
    new_entry.pr2       = disp_data.pr2;
    new_entry.imm       = disp_data.imm;
    new_entry.rob_index = disp_data.rob_index;
    new_entry.pr1_ready = disp_data.pr1_ready || (disp_data.pr1 == '0)
                       || cdb_match(cdb_valid, cdb_tag, disp_data.pr1);
    new_entry.pr2_ready = disp_data.pr2_ready || (disp_data.pr2 == '0)
                       || cdb_match(cdb_valid, cdb_tag, disp_data.pr2);
    // Survivors older than this one number count-fire after the edge.
    new_entry.age       = 3'(count_q - {3'b000, fire});
  end

  // Next-state: retire the issued entry, compact ages, apply wakeup to
  // survivors, insert, and let flush override everything.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        if (fire && grant[i]) begin
          entries_d[i].valid = 1'b0;
        end else begin
          if (fire && (entries_q[i].age > sel_age)) begin
            entries_d[i].age = entries_q[i].age - 3'd1;
          end
          if (cdb_match(cdb_valid, cdb_tag, entries_q[i].pr1)) begin
            entries_d[i].pr1_ready = 1'b1;
          end
          if (cdb_match(cdb_valid, cdb_tag, entries_q[i].pr2)) begin
            entries_d[i].pr2_ready = 1'b1;
          end
        end
      end
      if (insert && ins_sel[i]) begin
        entries_d[i] = new_entry;
      end
      if (flush) begin
        entries_d[i] = '0;
      end
    end
    count_d = count_q + {3'b000, insert} - {3'b000, fire};
    if (flush) begin
      count_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station (FU_ID set to MEM so the stamp is
// visible). Build with RS_WAKEUP_BYPASS_EN to exercise the bypass variant.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam logic [1:0] TB_FU = FU_MEM;
`ifdef RS_WAKEUP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                  clk;
  logic                  reset;
  logic                  flush;
  logic                  disp_valid;
  dispatch_pipeline_data disp_data;
  logic                  disp_ready;
  logic                  cdb_valid;
  logic [PREG_W-1:0]     cdb_tag;
  logic                  issue_valid;
  logic                  issue_ready;
  rs_data                issue_data;
  logic [3:0]            occupancy;

  int nvec = 0;
  int nerr = 0;

  reservation_station #(
    .DEPTH (8),
    .FU_ID (TB_FU)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .disp_valid  (disp_valid),
    .disp_data   (disp_data),
    .disp_ready  (disp_ready),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_data  (issue_data),
    .occupancy   (occupancy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers: advance one edge, then settle 1ns before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic dispatch_pipeline_data mk(input logic [6:0] prd, input logic [6:0] pr1,
                                               input logic r1, input logic [6:0] pr2,
                                               input logic r2, input logic [4:0] rob);
    dispatch_pipeline_data d;
    d.Opcode    = 7'h33;
    d.prd       = prd;
    d.pr1       = pr1;
    d.pr1_ready = r1;
    d.pr2       = pr2;
    d.pr2_ready = r2;
    d.imm       = 32'hA000_0000 | 32'(rob);
    d.rob_index = rob;
    return d;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    nvec++; if (disp_ready !== 1'b1) begin nerr++; $display("FAIL reset_disp_ready got %b exp 1", disp_ready); end
    nvec++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL reset_issue_valid got %b exp 0", issue_valid); end
    nvec++; if (occupancy !== 4'd0) begin nerr++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    nvec++; if (issue_data !== '0) begin nerr++; $display("FAIL reset_issue_data got %h exp 0", issue_data); end
  endtask

  task automatic test_wakeup();
    issue_ready = 1'b0;
    disp_data   = mk(7'd40, 7'd5, 1'b0, 7'd0, 1'b0, 5'd9);
    disp_valid  = 1'b1;
    tick();
    disp_valid = 1'b0;
    nvec++; if (occupancy !== 4'd1) begin nerr++; $display("FAIL wk_occ got %0d exp 1", occupancy); end
    nvec++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL wk_not_ready0 got %b exp 0", issue_valid); end
    tick();
    nvec++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL wk_not_ready1 got %b exp 0", issue_valid); end
    cdb_valid = 1'b1;
    cdb_tag   = 7'd5;
    #1;
    nvec++; if (issue_valid !== BYP) begin nerr++; $display("FAIL wk_bcast_cycle got %b exp %b", issue_valid, BYP); end
    tick();
    cdb_valid = 1'b0;
    nvec++; if (issue_valid !== 1'b1) begin nerr++; $display("FAIL wk_after got %b exp 1", issue_valid); end
    nvec++; if (issue_data.fu !== TB_FU) begin nerr++; $display("FAIL wk_fu got %0d exp %0d", issue_data.fu, TB_FU); end
    nvec++; if (issue_data.rob_index !== 5'd9) begin nerr++; $display("FAIL wk_rob got %0d exp 9", issue_data.rob_index); end
    nvec++; if (issue_data.prd !== 7'd40) begin nerr++; $display("FAIL wk_prd got %0d exp 40", issue_data.prd); end
    nvec++; if (issue_data.valid !== 1'b1) begin nerr++; $display("FAIL wk_valid got %b exp 1", issue_data.valid); end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    nvec++; if (occupancy !== 4'd0) begin nerr++; $display("FAIL wk_drain_occ got %0d exp 0", occupancy); end
    nvec++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL wk_drain_iv got %b exp 0", issue_valid); end
  endtask

  task automatic test_in_order();
    logic [4:0] exp_rob [3];
    exp_rob[0] = 5'd1; exp_rob[1] = 5'd2; exp_rob[2] = 5'd3;
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp_data  = mk(7'(60 + i), 7'd0, 1'b0, 7'd0, 1'b1, exp_rob[i]);
      disp_valid = 1'b1;
      tick();
    end
    disp_valid  = 1'b0;
    issue_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      nvec++; if (occupancy !== 4'(3 - i)) begin nerr++; $display("FAIL ord_occ%0d got %0d exp %0d", i, occupancy, 3 - i); end
      nvec++; if (issue_data.rob_index !== exp_rob[i] || issue_valid !== 1'b1) begin
        nerr++; $display("FAIL ord_rob%0d got %0d/%b exp %0d/1", i, issue_data.rob_index, issue_valid, exp_rob[i]);
      end
      tick();
    end
    issue_ready = 1'b0;
    nvec++; if (occupancy !== 4'd0) begin nerr++; $display("FAIL ord_occ3 got %0d exp 0", occupancy); end
    nvec++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL ord_empty got %b exp 0", issue_valid); end
  endtask

  task automatic test_full();
    issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      disp_data  = mk(7'(50 + i), 7'(10 + i), 1'b0, 7'd0, 1'b0, 5'(i));
      disp_valid = 1'b1;
      tick();
    end
    disp_valid = 1'b0;
    nvec++; if (occupancy !== 4'd8) begin nerr++; $display("FAIL full_occ got %0d exp 8", occupancy); end
    nvec++; if (disp_ready !== 1'b0) begin nerr++; $display("FAIL full_ready got %b exp 0", disp_ready); end
    nvec++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL full_iv got %b exp 0", issue_valid); end
    // Extra, fully ready dispatch must be refused.
    disp_data  = mk(7'd99, 7'd0, 1'b1, 7'd0, 1'b1, 5'd31);
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
    nvec++; if (occupancy !== 4'd8) begin nerr++; $display("FAIL full_extra_occ got %0d exp 8", occupancy); end
    nvec++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL full_extra_iv got %b exp 0", issue_valid); end
    // Wake entry 3 (pr1 = 13).
    cdb_valid = 1'b1;
    cdb_tag   = 7'd13;
    tick();
    cdb_valid = 1'b0;
    nvec++; if (issue_valid !== 1'b1 || issue_data.rob_index !== 5'd3) begin
      nerr++; $display("FAIL full_wake got %b/%0d exp 1/3", issue_valid, issue_data.rob_index);
    end
    issue_ready = 1'b1;
    #1;
    nvec++; if (disp_ready !== 1'b0) begin nerr++; $display("FAIL full_no_comb_ready got %b exp 0", disp_ready); end
    tick();
    issue_ready = 1'b0;
    nvec++; if (occupancy !== 4'd7) begin nerr++; $display("FAIL full_after_occ got %0d exp 7", occupancy); end
    nvec++; if (disp_ready !== 1'b1) begin nerr++; $display("FAIL full_after_ready got %b exp 1", disp_ready); end
    // New ready entry lands in freed slot 3 as the youngest (age 7).
    disp_data  = mk(7'd70, 7'd0, 1'b0, 7'd0, 1'b0, 5'd20);
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
    nvec++; if (occupancy !== 4'd8) begin nerr++; $display("FAIL refill_occ got %0d exp 8", occupancy); end
    nvec++; if (issue_valid !== 1'b1 || issue_data.rob_index !== 5'd20) begin
      nerr++; $display("FAIL refill_sel got %b/%0d exp 1/20", issue_valid, issue_data.rob_index);
    end
    // Wake entry 7 (older than slot-3 newcomer): it must preempt.
    cdb_valid = 1'b1;
    cdb_tag   = 7'd17;
    tick();
    cdb_valid = 1'b0;
    nvec++; if (issue_data.rob_index !== 5'd7) begin nerr++; $display("FAIL preempt_rob got %0d exp 7", issue_data.rob_index); end
    issue_ready = 1'b1;
    tick();
    nvec++; if (occupancy !== 4'd7 || issue_data.rob_index !== 5'd20) begin
      nerr++; $display("FAIL preempt_next got %0d/%0d exp 7/20", occupancy, issue_data.rob_index);
    end
    tick();
    issue_ready = 1'b0;
    nvec++; if (occupancy !== 4'd6) begin nerr++; $display("FAIL preempt_occ got %0d exp 6", occupancy); end
    nvec++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL preempt_iv got %b exp 0", issue_valid); end
  endtask

  task automatic test_flush();
    // Six entries remain (pr1 = 10,11,12,14,15,16); make entry 0 eligible.
    cdb_valid = 1'b1;
    cdb_tag   = 7'd10;
    tick();
    cdb_valid = 1'b0;
    nvec++; if (issue_valid !== 1'b1 || issue_data.rob_index !== 5'd0) begin
      nerr++; $display("FAIL fl_pre got %b/%0d exp 1/0", issue_valid, issue_data.rob_index);
    end
    flush       = 1'b1;
    disp_data   = mk(7'd80, 7'd0, 1'b1, 7'd0, 1'b1, 5'd25);
    disp_valid  = 1'b1;
    issue_ready = 1'b1;
    tick();
    flush       = 1'b0;
    disp_valid  = 1'b0;
    issue_ready = 1'b0;
    nvec++; if (occupancy !== 4'd0) begin nerr++; $display("FAIL fl_occ got %0d exp 0", occupancy); end
    nvec++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL fl_iv got %b exp 0", issue_valid); end
    nvec++; if (disp_ready !== 1'b1) begin nerr++; $display("FAIL fl_ready got %b exp 1", disp_ready); end
    tick();
    nvec++; if (occupancy !== 4'd0 || issue_valid !== 1'b0) begin
      nerr++; $display("FAIL fl_dropped got %0d/%b exp 0/0", occupancy, issue_valid);
    end
  endtask

  task automatic test_cdb_at_insert();
    issue_ready = 1'b0;
    disp_data   = mk(7'd90, 7'd9, 1'b0, 7'd12, 1'b1, 5'd11);
    disp_valid  = 1'b1;
    cdb_valid   = 1'b1;
    cdb_tag     = 7'd9;
    tick();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    nvec++; if (occupancy !== 4'd1) begin nerr++; $display("FAIL ci_occ got %0d exp 1", occupancy); end
    nvec++; if (issue_valid !== 1'b1) begin nerr++; $display("FAIL ci_iv got %b exp 1", issue_valid); end
    nvec++; if (issue_data.pr1_ready !== 1'b1) begin nerr++; $display("FAIL ci_pr1_ready got %b exp 1", issue_data.pr1_ready); end
    nvec++; if (issue_data.rob_index !== 5'd11) begin nerr++; $display("FAIL ci_rob got %0d exp 11", issue_data.rob_index); end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    nvec++; if (occupancy !== 4'd0) begin nerr++; $display("FAIL ci_drain got %0d exp 0", occupancy); end
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    disp_valid  = 1'b0;
    disp_data   = '0;
    cdb_valid   = 1'b0;
    cdb_tag     = '0;
    issue_ready = 1'b0;
    test_reset();
    test_wakeup();
    test_in_order();
    test_full();
    test_flush();
    test_cdb_at_insert();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
